// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the floating-point to decimal conversion path:
// default field widths, the exponent bias helper, the converter state
// encoding and the width of one BCD digit.
// ----------------------------------------------------------------------------
package fp_pkg;

   localparam int EXP_W_DEF = 8;
   localparam int MAN_W_DEF = 23;
   localparam int BCD_W     = 4;
   localparam int STATE_W   = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      DIGIT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Exponent bias for an exponent field of the given width.
   function automatic int bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/fp_align.sv
// ----------------------------------------------------------------------------
// fp_align
// Combinational split of a floating-point word into an integer magnitude and
// a left-aligned binary fraction. Bits falling below the fraction LSB are
// truncated. The parent registers every output.
//
// Ports:
//   word     in   {sign, exp, man}
//   sign     out  sign bit of word
//   int_part out  integer magnitude (all ones on overflow)
//   frac     out  binary fraction, MSB has weight 1/2
//   special  out  exponent all ones (Inf/NaN)
//   ovf      out  integer part does not fit in INT_W
//   zero     out  integer part and fraction are both zero
// ----------------------------------------------------------------------------
module fp_align
   import fp_pkg::*;
#(
   parameter int EXP_W  = EXP_W_DEF,
   parameter int MAN_W  = MAN_W_DEF,
   parameter int INT_W  = 24,
   parameter int FRAC_W = 24
) (
   input  logic [EXP_W+MAN_W:0] word,
   output logic                 sign,
   output logic [INT_W-1:0]     int_part,
   output logic [FRAC_W-1:0]    frac,
   output logic                 special,
   output logic                 ovf,
   output logic                 zero
);

   localparam int BIAS = bias(EXP_W);

   logic [EXP_W-1:0] exp_f;
   logic [MAN_W-1:0] man;
   logic [MAN_W:0]   m;
   logic [MAN_W-1:0] low_bits;
   int               e_unb;

   assign sign  = word[EXP_W+MAN_W];
   assign exp_f = word[EXP_W+MAN_W-1 -: EXP_W];
   assign man   = word[MAN_W-1:0];
   assign m     = {(exp_f != '0), man};

   // Denormals share the smallest normal exponent, only without hidden bit.
   assign e_unb = (exp_f == '0) ? (1 - BIAS) : (int'(exp_f) - BIAS);

   // The hidden bit always leaves the low MAN_W bits when shifted by E >= 0,
   // so the fractional bits of m are exactly the stored mantissa shifted.
   always_comb begin
      int_part = '0;
      frac     = '0;
      special  = 1'b0;
      ovf      = 1'b0;
      low_bits = '0;
      if (&exp_f) begin
         special = 1'b1;
      end else if (e_unb >= INT_W) begin
         ovf      = 1'b1;
         int_part = '1;
      end else if (e_unb >= 0) begin
         if (e_unb <= MAN_W) begin
            int_part = INT_W'(m >> (MAN_W - e_unb));
            low_bits = man << e_unb;
            frac     = FRAC_W'(low_bits) << (FRAC_W - MAN_W);
         end else begin
            int_part = INT_W'(m) << (e_unb - MAN_W);
         end
      end else begin
         frac = (FRAC_W'(m) << (FRAC_W - MAN_W - 1)) >> (-e_unb - 1);
      end
   end

   assign zero = !special && !ovf && (int_part == '0) && (frac == '0);

endmodule

// File: rtl/fp2dec_seq.sv
// ----------------------------------------------------------------------------
// fp2dec_seq
// Sequential floating-point to decimal converter. Accepts one word on the
// input handshake, splits it into integer part and binary fraction, then
// produces up to NDIG BCD fraction digits by repeated multiply-by-10 and
// presents the result on the output handshake.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid/ready input handshake, in_data = {sign, exp, man}
//   out_valid/ready output handshake
//   out_sign       sign of the input
//   out_int        integer magnitude
//   out_frac_bcd   fraction digits, first digit in the top nibble
//   out_zero       value is zero after truncation
//   out_ovf        integer part does not fit in INT_W
//   out_special    Inf/NaN input
// ----------------------------------------------------------------------------
module fp2dec_seq
   import fp_pkg::*;
#(
   parameter int EXP_W  = EXP_W_DEF,
   parameter int MAN_W  = MAN_W_DEF,
   parameter int INT_W  = 24,
   parameter int FRAC_W = 24,
   parameter int NDIG   = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_sign,
   output logic [INT_W-1:0]       out_int,
   output logic [BCD_W*NDIG-1:0]  out_frac_bcd,
   output logic                   out_zero,
   output logic                   out_ovf,
   output logic                   out_special
);

   localparam int CNT_W = $clog2(NDIG + 1);

   state_t                state;
   state_t                state_next;
   logic [EXP_W+MAN_W:0]  data_q;
   logic [FRAC_W-1:0]     frac_q;
   logic [CNT_W-1:0]      dig_cnt;

   logic                  a_sign;
   logic [INT_W-1:0]      a_int;
   logic [FRAC_W-1:0]     a_frac;
   logic                  a_special;
   logic                  a_ovf;
   logic                  a_zero;

   logic [FRAC_W+3:0]     prod;
   logic [BCD_W-1:0]      digit;
   logic [FRAC_W-1:0]     frac_next;
   logic                  last_digit;
   logic                  accept;
   logic                  release_out;

   fp_align #(
      .EXP_W  (EXP_W),
      .MAN_W  (MAN_W),
      .INT_W  (INT_W),
      .FRAC_W (FRAC_W)
   ) u_align (
      .word     (data_q),
      .sign     (a_sign),
      .int_part (a_int),
      .frac     (a_frac),
      .special  (a_special),
      .ovf      (a_ovf),
      .zero     (a_zero)
   );

   assign in_ready    = (state == IDLE) && !rst;
   assign accept      = in_valid && in_ready;
   assign release_out = out_valid && out_ready;

   // The four bits above the fraction after multiplying by 10 are the next
   // decimal digit; the remainder keeps feeding the loop.
   assign prod       = (FRAC_W+4)'(frac_q) * (FRAC_W+4)'(10);
   assign digit      = prod[FRAC_W+3:FRAC_W];
   assign frac_next  = prod[FRAC_W-1:0];
   assign last_digit = (dig_cnt == CNT_W'(NDIG - 1)) || (frac_next == '0);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (accept) state_next = ALIGN;
         ALIGN: begin
            if (a_special || a_ovf || (a_frac == '0)) begin
               state_next = DONE;
            end else begin
               state_next = DIGIT;
            end
         end
         DIGIT: if (last_digit) state_next = DONE;
         DONE:  if (release_out) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath. The BCD register is cleared in ALIGN and each digit is
   // written at its final nibble, so an early exit leaves trailing zeros and
   // the first digit in the top nibble. out_valid rises one cycle after
   // entering DONE and falls in the cycle after the output handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q       <= '0;
         frac_q       <= '0;
         dig_cnt      <= '0;
         out_valid    <= 1'b0;
         out_sign     <= 1'b0;
         out_int      <= '0;
         out_frac_bcd <= '0;
         out_zero     <= 1'b0;
         out_ovf      <= 1'b0;
         out_special  <= 1'b0;
      end else begin
         out_valid <= (state == DONE) && !release_out;
         case (state)
            IDLE: begin
               if (accept) data_q <= in_data;
            end
            ALIGN: begin
               out_sign     <= a_sign;
               out_int      <= a_int;
               out_zero     <= a_zero;
               out_ovf      <= a_ovf;
               out_special  <= a_special;
               out_frac_bcd <= '0;
               frac_q       <= a_frac;
               dig_cnt      <= '0;
            end
            DIGIT: begin
               out_frac_bcd[BCD_W*(NDIG-1-int'(dig_cnt)) +: BCD_W] <= digit;
               frac_q  <= frac_next;
               dig_cnt <= dig_cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp2dec_seq.sv
// ----------------------------------------------------------------------------
// tb_fp2dec_seq
// Self-checking bench for fp2dec_seq (FP32 defaults). Expected results come
// from hand-worked constants for the directed words and from an arithmetic
// reference model for the random words.
// ----------------------------------------------------------------------------
module tb_fp2dec_seq;

   typedef struct packed {
      logic        sign;
      logic [23:0] int_v;
      logic [23:0] bcd;
      logic        zero;
      logic        ovf;
      logic        special;
      logic [7:0]  lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_sign;
   logic [23:0] out_int;
   logic [23:0] out_frac_bcd;
   logic        out_zero;
   logic        out_ovf;
   logic        out_special;

   int test_cnt = 0;
   int fail_cnt = 0;

   fp2dec_seq dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sign     (out_sign),
      .out_int      (out_int),
      .out_frac_bcd (out_frac_bcd),
      .out_zero     (out_zero),
      .out_ovf      (out_ovf),
      .out_special  (out_special)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // One comparison: counts it, and reports tag/observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] expv);
      test_cnt++;
      assert (obs === expv) else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Reference: value = m * 2^(E-23); scaling by 2^24 gives integer part in
   // the upper bits and a truncated 24-bit binary fraction in the lower bits.
   // Decimal digits are floor(frac*10 / 2^24) repeated until six digits or
   // the fraction runs out.
   function automatic exp_t model(input logic [31:0] w);
      exp_t   r;
      int     e_unb;
      int     sh;
      int     n;
      longint m;
      longint x;
      longint fr;
      longint d;
      r = '0;
      r.sign = w[31];
      r.lat  = 8'd2;
      if (w[30:23] == 8'hFF) begin
         r.special = 1'b1;
      end else begin
         e_unb = (w[30:23] == 8'h00) ? -126 : int'(w[30:23]) - 127;
         m = longint'(w[22:0]);
         if (w[30:23] != 8'h00) m = m + (longint'(1) << 23);
         if (e_unb >= 24) begin
            r.ovf   = 1'b1;
            r.int_v = 24'hFFFFFF;
         end else begin
            sh = e_unb + 1;
            if (sh >= 0) x = m << sh;
            else if (-sh > 40) x = 0;
            else x = m >> (-sh);
            r.int_v = 24'(x >> 24);
            fr = x & 64'hFFFFFF;
            r.zero = (r.int_v == 24'd0) && (fr == 0);
            n = 0;
            while (fr != 0 && n < 6) begin
               fr = fr * 10;
               d  = fr >> 24;
               fr = fr & 64'hFFFFFF;
               r.bcd = r.bcd | (24'(d) << (4 * (5 - n)));
               n++;
            end
            r.lat = 8'(2 + n);
         end
      end
      return r;
   endfunction

   function automatic logic [63:0] packResult(input exp_t e);
      return 64'({e.sign, e.int_v, e.bcd, e.zero, e.ovf, e.special});
   endfunction

   // Full transaction: accept, measure latency, check every output field,
   // hold out_ready low for 'hold' cycles, then complete the handshake.
   task automatic applyStimulus(input logic [31:0] w, input int hold, input exp_t e);
      bit got;
      int lat;
      @(negedge clk);
      in_data   = w;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      got = 0;
      for (int i = 0; i < 40; i++) begin
         if (in_ready === 1'b1) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("accept", 64'(got), 64'd1);
      if (!got) begin
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      lat = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (out_valid === 1'b1) break;
      end
      checkOutput($sformatf("latency %h", w), 64'(lat), 64'(e.lat));
      checkOutput("in_ready_busy", 64'(in_ready), 64'd0);
      checkOutput($sformatf("sign %h", w), 64'(out_sign), 64'(e.sign));
      checkOutput($sformatf("int %h", w), 64'(out_int), 64'(e.int_v));
      checkOutput($sformatf("bcd %h", w), 64'(out_frac_bcd), 64'(e.bcd));
      checkOutput($sformatf("flags %h", w),
                  64'({out_zero, out_ovf, out_special}),
                  64'({e.zero, e.ovf, e.special}));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         checkOutput("hold_valid", 64'(out_valid), 64'd1);
         checkOutput("hold_ready", 64'(in_ready), 64'd0);
         checkOutput("hold_stable",
                     64'({out_sign, out_int, out_frac_bcd, out_zero, out_ovf, out_special}),
                     packResult(e));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("valid_drop", 64'(out_valid), 64'd0);
      checkOutput("ready_back", 64'(in_ready), 64'd1);
   endtask

   initial begin
      bit          seen;
      logic [31:0] w;
      logic [7:0]  ex;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_outputs",
                  64'({out_valid, out_sign, out_int, out_frac_bcd, out_zero, out_ovf, out_special}),
                  64'd0);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);

      // Directed words with hand-worked results.
      applyStimulus(32'h40490FDB, 0, '{1'b0, 24'd3,       24'h141592, 1'b0, 1'b0, 1'b0, 8'd8});
      applyStimulus(32'h3FC00000, 0, '{1'b0, 24'd1,       24'h500000, 1'b0, 1'b0, 1'b0, 8'd3});
      applyStimulus(32'h3DCCCCCD, 0, '{1'b0, 24'd0,       24'h099999, 1'b0, 1'b0, 1'b0, 8'd8});
      applyStimulus(32'hC1200000, 0, '{1'b1, 24'd10,      24'h000000, 1'b0, 1'b0, 1'b0, 8'd2});
      applyStimulus(32'h7F800000, 0, '{1'b0, 24'd0,       24'h000000, 1'b0, 1'b0, 1'b1, 8'd2});
      applyStimulus(32'h4B800000, 0, '{1'b0, 24'hFFFFFF,  24'h000000, 1'b0, 1'b1, 1'b0, 8'd2});
      applyStimulus(32'h80000000, 0, '{1'b1, 24'd0,       24'h000000, 1'b1, 1'b0, 1'b0, 8'd2});

      // Backpressure on pi.
      applyStimulus(32'h40490FDB, 5, '{1'b0, 24'd3,       24'h141592, 1'b0, 1'b0, 1'b0, 8'd8});

      // Edge words through the reference model: NaN, tiny denormal, 1.0,
      // largest in-range value.
      applyStimulus(32'h7FC00001, 1, model(32'h7FC00001));
      applyStimulus(32'h00000001, 0, model(32'h00000001));
      applyStimulus(32'h3F800000, 0, model(32'h3F800000));
      applyStimulus(32'h4B7FFFFF, 0, model(32'h4B7FFFFF));

      // Reset during the third DIGIT cycle aborts the conversion.
      @(negedge clk);
      in_data  = 32'h40490FDB;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_outputs",
                  64'({out_valid, out_sign, out_int, out_frac_bcd, out_zero, out_ovf, out_special}),
                  64'd0);
      checkOutput("abort_in_ready_in_rst", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) seen = 1;
      end
      checkOutput("abort_no_valid", 64'(seen), 64'd0);

      // Random words, exponent mostly in the interesting range.
      for (int k = 0; k < 30; k++) begin
         w = $urandom;
         if (k % 5 != 0) begin
            ex = 8'($urandom_range(100, 155));
            w[30:23] = ex;
         end
         applyStimulus(w, int'($urandom_range(0, 3)), model(w));
      end

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

   // Global time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not finish, observed running, expected done");
      $fatal(1, "[TB] timeout");
   end

endmodule
